// File: rtl/acc_seq_if.sv
// Request/response handshake bundle between a requesting unit and acc_seq.
interface acc_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_operand;
    logic [3:0] req_count;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_carry;

    modport master (
        output req_valid, req_op, req_operand, req_count, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry
    );

    modport slave (
        input  req_valid, req_op, req_operand, req_count, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry
    );
endinterface

// File: rtl/acc_seq.sv
// Sequencer for the 4-bit add/sub/load accumulator datapath: steps one request
// at a time through the datapath and returns the result with a carry flag.
module acc_seq (
    input  logic       clk,
    input  logic       reset,
    acc_seq_if.slave   bus,
    output logic [3:0] dp_A,
    output logic       dp_sel0,
    output logic       dp_sel1,
    input  logic [3:0] dp_S,
    input  logic       dp_cout
);
    typedef enum logic [1:0] {OP_LOAD = 2'd0, OP_ADD = 2'd1, OP_SUB = 2'd2, OP_MUL = 2'd3} op_t;
    typedef enum logic [2:0] {IDLE, EXEC, MCLR, MADD, RESP} state_t;

    state_t     state;
    logic [1:0] op;
    logic [3:0] operand;
    logic [3:0] count;
    logic [3:0] remain;
    logic       sticky;

    // Gated with reset so the requester never sees ready while reset is held.
    assign bus.req_ready = (state == IDLE) && reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            op             <= 2'd0;
            operand        <= 4'd0;
            count          <= 4'd0;
            remain         <= 4'd0;
            sticky         <= 1'b0;
            dp_A           <= 4'd0;
            dp_sel0        <= 1'b0;
            dp_sel1        <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= 4'd0;
            bus.rsp_carry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op      <= bus.req_op;
                        operand <= bus.req_operand;
                        count   <= bus.req_count;
                        if (bus.req_op == OP_MUL) begin
                            state   <= MCLR;
                            dp_A    <= 4'd0;
                            dp_sel0 <= 1'b0;
                            dp_sel1 <= 1'b1;
                        end else begin
                            state   <= EXEC;
                            dp_A    <= bus.req_operand;
                            dp_sel0 <= (bus.req_op == OP_SUB);
                            dp_sel1 <= (bus.req_op == OP_LOAD);
                        end
                    end
                end
                EXEC: begin
                    bus.rsp_result <= dp_S;
                    bus.rsp_carry  <= (op == OP_LOAD) ? 1'b0 : dp_cout;
                    bus.rsp_valid  <= 1'b1;
                    dp_A           <= 4'd0;
                    dp_sel0        <= 1'b0;
                    dp_sel1        <= 1'b0;
                    state          <= RESP;
                end
                MCLR: begin
                    remain <= count;
                    sticky <= 1'b0;
                    if (count == 4'd0) begin
                        bus.rsp_result <= dp_S;
                        bus.rsp_carry  <= 1'b0;
                        bus.rsp_valid  <= 1'b1;
                        dp_A           <= 4'd0;
                        dp_sel1        <= 1'b0;
                        state          <= RESP;
                    end else begin
                        dp_A    <= operand;
                        dp_sel1 <= 1'b0;
                        state   <= MADD;
                    end
                end
                MADD: begin
                    remain <= remain - 4'd1;
                    sticky <= sticky | dp_cout;
                    // Final add: the carry of this step must be folded in directly.
                    if (remain == 4'd1) begin
                        bus.rsp_result <= dp_S;
                        bus.rsp_carry  <= sticky | dp_cout;
                        bus.rsp_valid  <= 1'b1;
                        dp_A           <= 4'd0;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_seq.sv
// Bench for acc_seq: behavioural accumulator datapath, vector table with a
// scoreboard queue, plus backpressure and mid-operation reset sequences.
module tb_acc_seq;
    logic       clk;
    logic       reset;
    logic [3:0] dp_A;
    logic       dp_sel0;
    logic       dp_sel1;
    logic [3:0] dp_S;
    logic       dp_cout;
    logic [3:0] acc;
    logic [4:0] sum;

    acc_seq_if bus();

    acc_seq dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .dp_A   (dp_A),
        .dp_sel0(dp_sel0),
        .dp_sel1(dp_sel1),
        .dp_S   (dp_S),
        .dp_cout(dp_cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Datapath model: the accumulator registers S on every edge.
    always_comb begin
        sum     = {1'b0, acc} + {1'b0, (dp_sel0 ? ~dp_A : dp_A)} + {4'd0, dp_sel0};
        dp_S    = dp_sel1 ? dp_A : sum[3:0];
        dp_cout = sum[4];
    end

    always @(posedge clk) acc <= !reset ? 4'd0 : dp_S;

    typedef struct {
        logic [1:0] op;
        logic [3:0] operand;
        logic [3:0] count;
        logic [3:0] res;
        logic       carry;
        int         hold;
        int         idle;
    } vec_t;

    typedef struct {
        logic [3:0] res;
        logic       carry;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int   cyc;
        int   lat;
        exp_t e;
        cyc = 0;
        while (!bus.req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("req_ready idle", 32'(bus.req_ready), 32'd1);
        bus.rsp_ready   = (v.hold == 0);
        bus.req_valid   = 1'b1;
        bus.req_op      = v.op;
        bus.req_operand = v.operand;
        bus.req_count   = v.count;
        sb.push_back('{v.res, v.carry});
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = (v.op == 2'd3) ? 32'(v.count) + 2 : 2;
        cyc = 1;
        while (!bus.rsp_valid && cyc < 40) begin
            if (v.op == 2'd3 && cyc == 1)
                check("mclr pattern", 32'({dp_A, dp_sel0, dp_sel1}), 32'({4'd0, 1'b0, 1'b1}));
            else if (v.op == 2'd3)
                check("madd pattern", 32'({dp_A, dp_sel0, dp_sel1}), 32'({v.operand, 2'b00}));
            else
                check("exec pattern", 32'({dp_A, dp_sel0, dp_sel1}),
                      32'({v.operand, (v.op == 2'd2), (v.op == 2'd0)}));
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(lat));
        e = sb.pop_front();
        if (!bus.rsp_valid) return;
        check("result", 32'(bus.rsp_result), 32'(e.res));
        check("carry", 32'(bus.rsp_carry), 32'(e.carry));
        check("req_ready in resp", 32'(bus.req_ready), 32'd0);
        if (v.hold > 0) begin
            for (int h = 0; h < v.hold; h++) begin
                bus.req_valid   = (h == 1);
                bus.req_op      = 2'd0;
                bus.req_operand = 4'd7;
                @(negedge clk);
                check("bp rsp_valid", 32'(bus.rsp_valid), 32'd1);
                check("bp result", 32'(bus.rsp_result), 32'(e.res));
                check("bp req_ready", 32'(bus.req_ready), 32'd0);
                check("bp acc", 32'(acc), 32'(e.res));
            end
            bus.req_valid = 1'b0;
            bus.rsp_ready = 1'b1;
        end
        @(negedge clk);
        check("rsp_valid falls", 32'(bus.rsp_valid), 32'd0);
        check("acc after op", 32'(acc), 32'(e.res));
        for (int i = 0; i < v.idle; i++) begin
            @(negedge clk);
            check("idle acc", 32'(acc), 32'(e.res));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        vec_t v;
        bit   seen;
        tbl = '{
            '{2'd0, 4'd5,  4'd0,  4'd5,  1'b0, 0, 10},
            '{2'd1, 4'd12, 4'd0,  4'd1,  1'b1, 0, 0},
            '{2'd0, 4'd5,  4'd0,  4'd5,  1'b0, 0, 0},
            '{2'd2, 4'd3,  4'd0,  4'd2,  1'b1, 0, 0},
            '{2'd2, 4'd7,  4'd0,  4'd11, 1'b0, 0, 0},
            '{2'd3, 4'd3,  4'd5,  4'd15, 1'b0, 0, 0},
            '{2'd3, 4'd6,  4'd3,  4'd2,  1'b1, 0, 0},
            '{2'd3, 4'd9,  4'd0,  4'd0,  1'b0, 0, 0},
            '{2'd1, 4'd4,  4'd0,  4'd4,  1'b0, 4, 3},
            '{2'd1, 4'd15, 4'd0,  4'd3,  1'b1, 0, 0},
            '{2'd2, 4'd3,  4'd0,  4'd0,  1'b1, 0, 0},
            '{2'd3, 4'd15, 4'd1,  4'd15, 1'b0, 0, 0},
            '{2'd3, 4'd15, 4'd15, 4'd1,  1'b1, 0, 0},
            '{2'd2, 4'd2,  4'd0,  4'd15, 1'b0, 0, 0}
        };

        bus.req_valid   = 1'b0;
        bus.req_op      = 2'd0;
        bus.req_operand = 4'd0;
        bus.req_count   = 4'd0;
        bus.rsp_ready   = 1'b1;
        reset           = 1'b0;
        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(bus.req_ready), 32'd0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset dp", 32'({dp_A, dp_sel0, dp_sel1}), 32'd0);
        check("reset rsp data", 32'({bus.rsp_result, bus.rsp_carry}), 32'd0);
        reset = 1'b1;
        #1;
        check("req_ready after release", 32'(bus.req_ready), 32'd1);
        @(negedge clk);

        foreach (tbl[i]) run_op(tbl[i]);

        // Reset during the third MADD cycle of MUL 4x7 abandons the operation.
        bus.req_valid   = 1'b1;
        bus.req_op      = 2'd3;
        bus.req_operand = 4'd4;
        bus.req_count   = 4'd7;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("third madd", 32'({dp_A, dp_sel0, dp_sel1}), 32'({4'd4, 2'b00}));
        reset = 1'b0;
        @(negedge clk);
        check("midreset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midreset req_ready", 32'(bus.req_ready), 32'd0);
        check("midreset dp", 32'({dp_A, dp_sel0, dp_sel1}), 32'd0);
        check("midreset rsp data", 32'({bus.rsp_result, bus.rsp_carry}), 32'd0);
        reset = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("no rsp after reset", 32'(seen), 32'd0);
        v = '{2'd0, 4'd9, 4'd0, 4'd9, 1'b0, 0, 0};
        run_op(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/acc_seq.md
# acc_seq

Command sequencer that drives the 4-bit add/subtract/load accumulator datapath from the control side. It accepts one operation request at a time over a valid/ready handshake. It issues the per-cycle operand and select pattern (A, sel0, sel1) that the datapath consumes, samples the datapath's S and somador_cout, and returns the result over a second valid/ready handshake. It sits between any requesting unit and the accumulator datapath, and is the only driver of that datapath's A, sel0 and sel1.

## Interface
Parameters:
- none; the datapath width is fixed at 4 bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low. reset=0 at a rising edge resets the block. The same net resets the datapath accumulator at system level.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  2  operation code: 00 LOAD, 01 ADD, 10 SUB, 11 MUL.
- req_operand  in  4  operand value.
- req_count  in  4  multiplier, MUL only; ignored for other operations.
- dp_A  out  4  datapath operand input.
- dp_sel0  out  1  datapath sel0: invert A and carry-in=1 (subtract).
- dp_sel1  out  1  datapath sel1: bypass the adder (load).
- dp_S  in  4  datapath S, the value the accumulator registers at the next edge.
- dp_cout  in  1  datapath adder carry-out.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_result  out  4  result value, equal to the accumulator contents after the operation.
- rsp_carry  out  1  carry flag, defined per operation below.

## Operation
Datapath contract, per cycle; the accumulator registers S every edge:
- sel1=1, sel0=0: S=A.
- sel1=0, sel0=0: S=acc+A.
- sel1=0, sel0=1: S=acc+~A+1, i.e. acc−A.
- HOLD pattern (A=0, sel0=0, sel1=0): S=acc. The block drives HOLD in every cycle that is not an operation step, so the accumulator never drifts.

Request accept: at an edge with req_valid=1 and req_ready=1, the block registers req_op, req_operand and req_count.

States:
- IDLE: req_ready=1, drives HOLD. On accept: LOAD, ADD or SUB go to EXEC; MUL goes to MCLR.
- EXEC: one step, then RESP.
  - LOAD drives sel1=1, sel0=0, A=operand.
  - ADD drives sel1=0, sel0=0, A=operand.
  - SUB drives sel1=0, sel0=1, A=operand.
- MCLR: drives sel1=1, sel0=0, A=0, clearing the accumulator. Loads the remaining-count register with count and clears the sticky carry. If count=0, go to RESP; otherwise go to MADD.
- MADD: drives sel1=0, sel0=0, A=operand. Each edge decrements the remaining count and ORs dp_cout into the sticky carry. Leaves for RESP on the edge where the remaining count goes 1→0.
- RESP: rsp_valid=1, drives HOLD, req_ready=0. On rsp_ready=1 at an edge, go to IDLE.

Result capture happens on the final step edge, from dp_S and dp_cout:
- LOAD: rsp_result=operand, rsp_carry=0.
- ADD: rsp_result=(acc+operand) mod 16, rsp_carry=dp_cout.
- SUB: rsp_result=(acc−operand) mod 16, rsp_carry=dp_cout (1 = no borrow).
- MUL: rsp_result=(operand×count) mod 16, rsp_carry=sticky OR of all MADD carries (1 = overflow). For count=0, the result is 0 and rsp_carry=0.

rsp_result and rsp_carry are stable for the whole RESP state.

## Timing
- Reset (reset=0 at an edge): state IDLE; dp_A=0, dp_sel0=0, dp_sel1=0, rsp_valid=0, rsp_result=0, rsp_carry=0.
- req_ready is 0 while reset is asserted and 1 in the first cycle after release.
- Reset mid-operation: the operation is abandoned and no response is produced.
- Latency from the accept edge to the first rsp_valid=1 cycle:
  - LOAD, ADD, SUB: 2 cycles.
  - MUL: count+2 cycles.
- Throughput: a new request can be accepted no earlier than the cycle after rsp_valid falls, so one operation is in flight at a time.
- req_ready and rsp_valid are never 1 in the same cycle.
- rsp_valid is not combinationally dependent on rsp_ready.
- Backpressure: RESP holds indefinitely; the accumulator is unchanged because HOLD is driven.
- dp_A, dp_sel0 and dp_sel1 are registered state decodes and glitch-free relative to clk.

## Test plan
- After reset, LOAD 5 → rsp_valid 2 cycles after accept, rsp_result=5, rsp_carry=0; the accumulator reads 5 during 10 idle cycles.
- Accumulator=5, ADD 12 → rsp_result=1, rsp_carry=1. Then LOAD 5, SUB 3 → rsp_result=2, rsp_carry=1. Then SUB 7 → rsp_result=11, rsp_carry=0.
- MUL operand=3, count=5 → dp_sel1=1 for 1 cycle, then 5 ADD cycles with A=3; rsp_valid 7 cycles after accept; rsp_result=15, rsp_carry=0.
- MUL operand=6, count=3 → rsp_result=2, rsp_carry=1. MUL operand=9, count=0 → rsp_result=0, rsp_carry=0, latency 2 cycles.
- Hold rsp_ready=0 for 4 cycles after rsp_valid rises → rsp_valid and rsp_result are stable, req_ready=0, and a req_valid pulse is ignored; the accumulator is unchanged.
- Assert reset=0 during the third MADD cycle of MUL 4×7 → next cycle is IDLE, rsp_valid=0, all outputs 0, and no response is produced; a following LOAD 9 completes normally with rsp_result=9.
